// File: rtl/reg_file_scoreboard_pkg.sv
// Shared widths and types for the register file / RAW scoreboard.
package reg_file_scoreboard_pkg;

  localparam int unsigned DATA         = 32;
  localparam int unsigned REG_WIDTH    = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned MAX_INFLIGHT = 3;
  localparam int unsigned PEND_WIDTH   = 2;

  // Outstanding destination writes for one register (EX, MEM, WB).
  typedef logic [PEND_WIDTH-1:0] pend_t;

endpackage

// File: rtl/reg_file_scoreboard_pending_counter.sv
// Per-register 2-bit inc/dec pending-write counter with overflow/underflow flags.
module pending_counter
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned MAX = reg_file_scoreboard_pkg::MAX_INFLIGHT
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  inc,
  input  logic  dec,
  output pend_t count,
  output logic  overflow,
  output logic  underflow
);

  // Simultaneous inc and dec cancel, so neither limit can be violated.
  assign overflow  = inc && !dec && (count == pend_t'(MAX));
  assign underflow = dec && !inc && (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !overflow) begin
      count <= count + pend_t'(1);
    end else if (dec && !inc && !underflow) begin
      count <= count - pend_t'(1);
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with write-through reads and per-register RAW scoreboard for decode stalls.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned DATA         = reg_file_scoreboard_pkg::DATA,
  parameter int unsigned REG_WIDTH    = reg_file_scoreboard_pkg::REG_WIDTH,
  parameter int unsigned NUM_REGS     = reg_file_scoreboard_pkg::NUM_REGS,
  parameter int unsigned MAX_INFLIGHT = reg_file_scoreboard_pkg::MAX_INFLIGHT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wb_valid,
  input  logic [REG_WIDTH-1:0] wb_read,
  input  logic [DATA-1:0]      wb_data,
  input  logic [REG_WIDTH-1:0] rs_addr,
  input  logic [REG_WIDTH-1:0] rt_addr,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic                 issue_valid,
  input  logic                 issue_writes,
  input  logic [REG_WIDTH-1:0] issue_dest,
  output logic [DATA-1:0]      rs_data,
  output logic [DATA-1:0]      rt_data,
  output logic                 stall,
  output logic [31:0]          stall_cycles,
  output logic                 sb_error
);

  logic [DATA-1:0]     regs [NUM_REGS];
  pend_t               pend [NUM_REGS];
  logic [NUM_REGS-1:0] overflow;
  logic [NUM_REGS-1:0] underflow;
  logic                wb_hit_rs;
  logic                wb_hit_rt;
  logic                hazard_rs;
  logic                hazard_rt;
  logic                issue_accept;
  logic                retire;

  assign retire       = wb_valid && (wb_read != '0);
  assign wb_hit_rs    = retire && (wb_read == rs_addr);
  assign wb_hit_rt    = retire && (wb_read == rt_addr);

  // regs[0] is never written, so the array read already returns 0 for R0.
  assign rs_data = wb_hit_rs ? wb_data : regs[rs_addr];
  assign rt_data = wb_hit_rt ? wb_data : regs[rt_addr];

  // Effective pending = pend minus a same-cycle retire; compared as pend > hit
  // so an erroneous retire at pend 0 cannot wrap into a false hazard.
  assign hazard_rs = rs_used && (rs_addr != '0) && (pend[rs_addr] > pend_t'(wb_hit_rs));
  assign hazard_rt = rt_used && (rt_addr != '0) && (pend[rt_addr] > pend_t'(wb_hit_rt));

  assign stall        = issue_valid && (hazard_rs || hazard_rt);
  assign issue_accept = issue_valid && !stall;

  assign pend[0]      = '0;
  assign overflow[0]  = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
    pending_counter #(
      .MAX(MAX_INFLIGHT)
    ) u_pending_counter (
      .clock    (clock),
      .reset    (reset),
      .inc      (issue_accept && issue_writes && (issue_dest == REG_WIDTH'(i))),
      .dec      (wb_valid && (wb_read == REG_WIDTH'(i))),
      .count    (pend[i]),
      .overflow (overflow[i]),
      .underflow(underflow[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (retire) begin
      regs[wb_read] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if ((|overflow) || (|underflow)) begin
      sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and randomized bench for reg_file_scoreboard against an array-based reference model.
module tb_reg_file_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_read;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_used;
  logic        rt_used;
  logic        issue_valid;
  logic        issue_writes;
  logic [4:0]  issue_dest;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic [31:0] stall_cycles;
  logic        sb_error;

  reg_file_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_read     (wb_read),
    .wb_data     (wb_data),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .issue_valid (issue_valid),
    .issue_writes(issue_writes),
    .issue_dest  (issue_dest),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .stall_cycles(stall_cycles),
    .sb_error    (sb_error)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [31:0] m_scnt;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input bit used, input logic [4:0] a);
    int eff;
    eff = m_pend[a] - ((wb_valid && wb_read == a) ? 1 : 0);
    return used && (a != 0) && (eff > 0);
  endfunction

  task automatic idle_inputs();
    reset = 0; wb_valid = 0; wb_read = 0; wb_data = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    issue_valid = 0; issue_writes = 0; issue_dest = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    logic [31:0] e_rs, e_rt;
    bit          e_stall, acc, inc, dec;
    @(negedge clock);
    #1;
    e_rs = (wb_valid && wb_read == rs_addr && rs_addr != 0) ? wb_data : m_regs[rs_addr];
    e_rt = (wb_valid && wb_read == rt_addr && rt_addr != 0) ? wb_data : m_regs[rt_addr];
    e_stall = issue_valid && (model_hazard(rs_used, rs_addr) || model_hazard(rt_used, rt_addr));
    check("rs_data", rs_data, e_rs);
    check("rt_data", rt_data, e_rt);
    check("stall", {31'b0, stall}, {31'b0, e_stall});
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0;
        m_pend[i] = 0;
      end
      m_scnt = 0;
      m_err  = 0;
    end else begin
      acc = issue_valid && !e_stall;
      inc = acc && issue_writes && issue_dest != 0;
      dec = wb_valid && wb_read != 0;
      if (dec) m_regs[wb_read] = wb_data;
      if (!(inc && dec && issue_dest == wb_read)) begin
        if (inc) begin
          if (m_pend[issue_dest] == 3) m_err = 1;
          else m_pend[issue_dest]++;
        end
        if (dec) begin
          if (m_pend[wb_read] == 0) m_err = 1;
          else m_pend[wb_read]--;
        end
      end
      if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
    @(posedge clock);
    #1;
    check("stall_cycles", stall_cycles, m_scnt);
    check("sb_error", {31'b0, sb_error}, {31'b0, m_err});
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 'x;
      m_pend[i] = 0;
    end
    m_scnt = 0;
    m_err  = 0;
    idle_inputs();
    @(posedge clock);
    #1;
    do_reset();

    // Reset contents, then R0 write is discarded.
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      cycle();
    end
    wb_valid = 1; wb_read = 0; wb_data = 32'd5;
    cycle();
    idle_inputs();
    cycle();
    check("r0_reads_zero", rs_data, 32'd0);
    check("r0_no_error", {31'b0, sb_error}, 32'd0);

    // RAW stall on R3 released by write-through.
    issue_valid = 1; issue_writes = 1; issue_dest = 3;
    cycle();
    issue_writes = 0; rs_addr = 3; rs_used = 1;
    repeat (3) cycle();
    check("stall_cycles_3", stall_cycles, 32'd3);
    wb_valid = 1; wb_read = 3; wb_data = 32'hDEAD_BEEF;
    #1;
    check("r3_release", {31'b0, stall}, 32'd0);
    check("r3_writethru", rs_data, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    rs_addr = 3;
    cycle();
    check("r3_array", rs_data, 32'hDEAD_BEEF);

    // Overflow on R7, then drain.
    idle_inputs();
    issue_valid = 1; issue_writes = 1; issue_dest = 7;
    repeat (3) cycle();
    check("r7_no_err_yet", {31'b0, sb_error}, 32'd0);
    cycle();
    check("r7_overflow", {31'b0, sb_error}, 32'd1);
    idle_inputs();
    issue_valid = 1; rs_addr = 7; rs_used = 1;
    #1;
    check("r7_busy", {31'b0, stall}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      wb_valid = 1; wb_read = 7; wb_data = 32'(100 + k);
      cycle();
    end
    idle_inputs();
    issue_valid = 1; rs_addr = 7; rs_used = 1;
    #1;
    check("r7_free", {31'b0, stall}, 32'd0);
    cycle();

    // Same-cycle issue and retire of R9 keeps pend at 1.
    do_reset();
    issue_valid = 1; issue_writes = 1; issue_dest = 9;
    cycle();
    wb_valid = 1; wb_read = 9; wb_data = 32'h99;
    cycle();
    idle_inputs();
    issue_valid = 1; rt_addr = 9; rt_used = 1;
    #1;
    check("r9_still_busy", {31'b0, stall}, 32'd1);
    cycle();

    // Underflow retire on R12 still writes data; error is sticky.
    do_reset();
    wb_valid = 1; wb_read = 12; wb_data = 32'h0000_1234;
    cycle();
    idle_inputs();
    rs_addr = 12;
    repeat (3) cycle();
    check("r12_data", rs_data, 32'h0000_1234);
    check("r12_sticky", {31'b0, sb_error}, 32'd1);

    // Reset mid-hazard on R4 (pend 2).
    do_reset();
    issue_valid = 1; issue_writes = 1; issue_dest = 4;
    repeat (2) cycle();
    issue_writes = 0; rs_addr = 4; rs_used = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    #1;
    check("post_reset_stall", {31'b0, stall}, 32'd0);
    check("post_reset_scnt", stall_cycles, 32'd0);
    cycle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      idle_inputs();
      reset        = ($urandom_range(0, 79) == 0);
      issue_valid  = $urandom_range(0, 3) != 0;
      issue_writes = $urandom_range(0, 1);
      issue_dest   = 5'($urandom_range(0, 7));
      rs_addr      = 5'($urandom_range(0, 7));
      rt_addr      = 5'($urandom_range(0, 7));
      rs_used      = $urandom_range(0, 1);
      rt_used      = $urandom_range(0, 1);
      wb_valid     = $urandom_range(0, 1);
      wb_data      = $urandom;
      wb_read      = 5'($urandom_range(0, 7));
      for (int t = 0; t < 8 && m_pend[wb_read] == 0; t++) begin
        wb_read = 5'($urandom_range(0, 7));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
